// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues 4-byte-aligned reads to a 1-cycle-latency instruction memory, queues
// the returned words with their pc, and hands the queue head to decode through
// a valid/ready handshake. An all-zero word stops fetch, and a flush redirects it.
// Optional macro FETCH_PERF_EN adds the perf_fetched/perf_stalls counters;
// without it both ports read as zero.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 12,
    parameter int                  INSTR_WIDTH = 32,
    parameter int                  QUEUE_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 12'h000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   fetch_valid,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic [INSTR_WIDTH-1:0] instr_out,
    input  logic                   decode_ready,
    input  logic                   flush,
    input  logic [PC_WIDTH-1:0]    flush_pc,
    output logic                   halted,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_stalls
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    req_pc_q;
    logic                   inflight;
    logic                   halt_flag;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [PC_WIDTH-1:0]    q_pc    [QUEUE_DEPTH];
    logic [INSTR_WIDTH-1:0] q_instr [QUEUE_DEPTH];

    logic           issue;
    logic           zero_resp;
    logic           push;
    logic           pop;
    logic [CNT_W:0] occupancy;
    logic [1:0]     flush_pc_unused;

    // Target alignment is forced, so the low redirect bits carry no information.
    assign flush_pc_unused = flush_pc[1:0];

    // Credit counts queued entries plus the response still in flight; a pop in
    // the same cycle does not free a slot for this cycle's issue.
    assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight);
    assign issue     = rst_n && !flush && !halt_flag &&
                       (occupancy < (CNT_W+1)'(QUEUE_DEPTH));
    assign zero_resp = inflight && (imem_rdata == '0);
    assign push      = inflight && !zero_resp && !flush;
    assign pop       = fetch_valid && decode_ready;

    assign imem_req    = issue;
    assign imem_addr   = pc;
    assign fetch_valid = (count != '0);
    assign pc_out      = fetch_valid ? q_pc[rd_ptr]    : '0;
    assign instr_out   = fetch_valid ? q_instr[rd_ptr] : '0;
    assign halted      = halt_flag && (count == '0) && !inflight;

    // pc, in-flight tracking, halt and queue pointers; flush overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            req_pc_q  <= RESET_PC;
            inflight  <= 1'b0;
            halt_flag <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else if (flush) begin
            pc        <= {flush_pc[PC_WIDTH-1:2], 2'b00};
            inflight  <= 1'b0;
            halt_flag <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            // A zero word stops fetch; a request issued alongside it is dropped
            // and pc parks just past the terminating word.
            if (zero_resp) begin
                halt_flag <= 1'b1;
                pc        <= req_pc_q + PC_WIDTH'(4);
                inflight  <= 1'b0;
            end else if (issue) begin
                req_pc_q <= pc;
                pc       <= pc + PC_WIDTH'(4);
                inflight <= 1'b1;
            end else begin
                inflight <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Queue storage; contents are don't-care while the entry is not valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= req_pc_q;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

    // The credit check should make a push into a full queue impossible.
    assert property (@(posedge clk) disable iff (!rst_n)
        (push && !pop) |-> (count < CNT_W'(QUEUE_DEPTH)));

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] stalls_q;

    // Event counters survive flushes; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else begin
            if (push)                         fetched_q <= fetched_q + 32'd1;
            if (fetch_valid && !decode_ready) stalls_q  <= stalls_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stalls  = stalls_q;
`else
    assign perf_fetched = 32'h0;
    assign perf_stalls  = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table, hand-written
// corner sequences, then randomized traffic against a queue-based reference.
module tb_fetch_unit;
    localparam int PW = 12;
    localparam int IW = 32;
    localparam int QD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata = '0;
    logic          fetch_valid;
    logic [PW-1:0] pc_out;
    logic [IW-1:0] instr_out;
    logic          decode_ready = 1'b0;
    logic          flush = 1'b0;
    logic [PW-1:0] flush_pc = '0;
    logic          halted;
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_stalls;

    always #5 clk = ~clk;

    fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .QUEUE_DEPTH(QD), .RESET_PC(12'h000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .fetch_valid(fetch_valid), .pc_out(pc_out),
        .instr_out(instr_out), .decode_ready(decode_ready), .flush(flush),
        .flush_pc(flush_pc), .halted(halted), .perf_fetched(perf_fetched),
        .perf_stalls(perf_stalls)
    );

    // Instruction memory: word-indexed, data appears one cycle after the request.
    logic [IW-1:0] mem [1024];
    always @(posedge clk) if (imem_req) imem_rdata <= mem[imem_addr[11:2]];

    int errors = 0;
    int checks = 0;
    bit mcheck = 1'b1;

    // Reference: queue of {pc, instr}, one outstanding read, sticky halt.
    typedef struct packed { logic [PW-1:0] pc; logic [IW-1:0] instr; } entry_t;
    entry_t        mq[$];
    logic [PW-1:0] m_pc, m_req_pc;
    bit            m_inflight, m_halt;
    logic [31:0]   m_fetched, m_stalls;

    typedef struct {
        bit ready; bit fl; logic [PW-1:0] fpc;
        bit req; logic [PW-1:0] addr; bit valid; logic [PW-1:0] pc; logic [IW-1:0] instr; bit hlt;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = 12'h000; m_req_pc = 12'h000;
        m_inflight = 0; m_halt = 0; m_fetched = 0; m_stalls = 0;
    endtask

    task automatic check_model();
        bit ev;
        bit er;
        ev = mq.size() != 0;
        er = !flush && !m_halt && (mq.size() + int'(m_inflight)) < QD;
        chk("m_imem_req", imem_req, er);
        chk("m_imem_addr", imem_addr, m_pc);
        chk("m_fetch_valid", fetch_valid, ev);
        chk("m_pc_out", pc_out, ev ? mq[0].pc : 12'h0);
        chk("m_instr_out", instr_out, ev ? mq[0].instr : 32'h0);
        chk("m_halted", halted, m_halt && !ev && !m_inflight);
`ifdef FETCH_PERF_EN
        chk("m_perf_fetched", perf_fetched, m_fetched);
        chk("m_perf_stalls", perf_stalls, m_stalls);
`else
        chk("m_perf_fetched", perf_fetched, 32'h0);
        chk("m_perf_stalls", perf_stalls, 32'h0);
`endif
    endtask

    task automatic model_update();
        bit ev;
        bit er;
        ev = mq.size() != 0;
        er = !m_halt && (mq.size() + int'(m_inflight)) < QD;
        if (ev && !decode_ready) m_stalls++;
        if (flush) begin
            mq.delete();
            m_inflight = 0; m_halt = 0;
            m_pc = {flush_pc[PW-1:2], 2'b00};
        end else begin
            if (ev && decode_ready) void'(mq.pop_front());
            if (m_inflight && imem_rdata != 0) begin
                mq.push_back({m_req_pc, imem_rdata});
                m_fetched++;
            end
            if (m_inflight && imem_rdata == 0) begin
                m_halt = 1; m_pc = m_req_pc + 12'd4; m_inflight = 0;
            end else if (er) begin
                m_req_pc = m_pc; m_pc = m_pc + 12'd4; m_inflight = 1;
            end else begin
                m_inflight = 0;
            end
        end
    endtask

    // Called at the falling edge: apply inputs, settle, compare against the model.
    task automatic drive(bit rdy, bit fl, logic [PW-1:0] fpc);
        decode_ready = rdy; flush = fl; flush_pc = fpc;
        #1;
        if (mcheck) check_model();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; decode_ready = 0; flush = 0; flush_pc = '0;
        #1;
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_fetch_valid", fetch_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_pc_out", pc_out, 12'h0);
        chk("rst_perf", {perf_fetched, perf_stalls}, 64'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill_plain();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h13 | (i << 7);
    endtask

    initial begin
        bit seen;
        tbl[0] = '{1, 0, 12'h000, 1, 12'h000, 0, 12'h000, 32'h0, 0};
        tbl[1] = '{1, 0, 12'h000, 1, 12'h004, 0, 12'h000, 32'h0, 0};
        tbl[2] = '{1, 0, 12'h000, 1, 12'h008, 1, 12'h000, 32'h00500093, 0};
        tbl[3] = '{1, 0, 12'h000, 1, 12'h00C, 1, 12'h004, 32'h00100113, 0};
        tbl[4] = '{1, 0, 12'h000, 0, 12'h00C, 0, 12'h000, 32'h0, 1};
        tbl[5] = '{1, 0, 12'h000, 0, 12'h00C, 0, 12'h000, 32'h0, 1};
        tbl[6] = '{1, 1, 12'h103, 0, 12'h00C, 0, 12'h000, 32'h0, 1};
        tbl[7] = '{1, 0, 12'h000, 1, 12'h100, 0, 12'h000, 32'h0, 0};

        @(negedge clk);

        // Table: first-fetch latency, halt on zero word at 8, then redirect.
        fill_plain();
        mem[0] = 32'h00500093; mem[1] = 32'h00100113; mem[2] = 32'h0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].ready, tbl[i].fl, tbl[i].fpc);
            chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].req);
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), fetch_valid, tbl[i].valid);
            chk($sformatf("tbl%0d_pc", i), pc_out, tbl[i].pc);
            chk($sformatf("tbl%0d_instr", i), instr_out, tbl[i].instr);
            chk($sformatf("tbl%0d_halted", i), halted, tbl[i].hlt);
            advance();
        end

        // Decode stalled for 10 cycles: queue fills to depth and fetch stops.
        fill_plain();
        do_reset();
        repeat (10) begin drive(0, 0, '0); advance(); end
        drive(0, 0, '0);
        chk("stall_valid", fetch_valid, 1'b1);
        chk("stall_pc_held", pc_out, 12'h000);
        chk("stall_req_off", imem_req, 1'b0);
`ifdef FETCH_PERF_EN
        chk("stall_perf_stalls", perf_stalls, 32'd8);
`else
        chk("stall_perf_stalls", perf_stalls, 32'd0);
`endif
        advance();

        // Flush with three queued entries and one read in flight.
        do_reset();
        repeat (4) begin drive(0, 0, '0); advance(); end
        drive(0, 1, 12'h103);
        chk("flush_req_off", imem_req, 1'b0);
        chk("flush_prev_valid", fetch_valid, 1'b1);
        advance();
        drive(1, 0, '0);
        chk("flush_valid_cleared", fetch_valid, 1'b0);
        chk("flush_new_addr", imem_addr, 12'h100);
        chk("flush_new_req", imem_req, 1'b1);
        advance();
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            drive(1, 0, '0);
            if (fetch_valid) begin
                seen = 1;
                chk("flush_first_pc", pc_out, 12'h100);
            end
            advance();
        end
        chk("flush_head_seen", seen, 1'b1);

        // pc wraps from 0xFFC to 0x000.
        do_reset();
        drive(1, 1, 12'hFFC); advance();
        drive(1, 0, '0); chk("wrap_addr_ffc", imem_addr, 12'hFFC); advance();
        drive(1, 0, '0); chk("wrap_addr_000", imem_addr, 12'h000); advance();
        drive(1, 0, '0); chk("wrap_head0", pc_out, 12'hFFC); advance();
        drive(1, 0, '0); chk("wrap_head1", pc_out, 12'h000); advance();

        // Asynchronous reset with an entry queued and a read in flight.
        do_reset();
        repeat (2) begin drive(0, 0, '0); advance(); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", fetch_valid, 1'b0);
        chk("arst_req", imem_req, 1'b0);
        chk("arst_halted", halted, 1'b0);
        chk("arst_pc_out", pc_out, 12'h0);
        @(negedge clk);
        do_reset();
        repeat (2) begin drive(0, 0, '0); advance(); end
        drive(0, 0, '0);
        chk("arst_first_valid", fetch_valid, 1'b1);
        chk("arst_first_pc", pc_out, 12'h000);
        advance();

        // Randomized traffic with sparse zero words, redirects and stalls.
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            if ($urandom_range(0, 19) == 0) mem[i] = 32'h0;
        end
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, PW'($urandom));
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
